// File: rtl/adc_ddr3_pkg.sv
// Shared definitions for the ADC-to-DDR3 capture writer: datapath widths,
// FSM state encoding and the sample-to-lane packing helper.
package adc_ddr3_pkg;

  localparam int LANES    = 16;
  localparam int LANE_W   = 16;
  localparam int DATA_W   = 256;
  localparam int ADDR_W   = 22;
  localparam int BE_W     = 32;
  localparam int SAMPLE_W = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } wr_state_e;

  // Returns word with the given 16-bit lane replaced by a zero-extended sample.
  function automatic logic [DATA_W-1:0] put_lane(input logic [DATA_W-1:0] word,
                                                 input logic [3:0]        lane,
                                                 input logic [SAMPLE_W-1:0] sample);
    logic [DATA_W-1:0] w;
    w = word;
    w[lane*LANE_W +: LANE_W] = {2'b00, sample};
    return w;
  endfunction

endpackage

// File: rtl/adc_ddr3_writer_fifo.sv
// adc_word_fifo: synchronous show-ahead FIFO of packed 256-bit words.
// The head word is always visible on rd_data; rd_en pops it. Writes to a
// full FIFO and reads from an empty one are ignored. clr flushes contents.
module adc_word_fifo
  import adc_ddr3_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = DATA_W
) (
  input  logic                       clk_200m,
  input  logic                       reset_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             full_s;
  logic             empty_s;
  logic             do_wr_s;
  logic             do_rd_s;

  assign full_s  = (count_r == CNT_FULL);
  assign empty_s = (count_r == {(AW+1){1'b0}});
  assign do_wr_s = wr_en && !full_s;
  assign do_rd_s = rd_en && !empty_s;

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = full_s;
  assign empty   = empty_s;
  assign count   = count_r;

  // Storage array: written at the tail on every accepted push.
  always_ff @(posedge clk_200m) begin
    if (do_wr_s && !clr) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop keeps the count.
  always_ff @(posedge clk_200m or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/adc_ddr3_writer.sv
// adc_ddr3_writer: packs 14-bit ADC samples sixteen to a 256-bit word,
// buffers the words and writes them to DDR3 as fixed-length Avalon-MM
// bursts at consecutive addresses, for a programmed number of bursts.
module adc_ddr3_writer
  import adc_ddr3_pkg::*;
#(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                clk_200m,
  input  logic                reset_n,
  input  logic                start,
  input  logic [21:0]         base_addr,
  input  logic [15:0]         num_bursts,
  input  logic                sample_valid,
  input  logic [13:0]         sample_data,
  output logic                avm_write,
  output logic [21:0]         avm_addr,
  output logic [255:0]        avm_write_data,
  output logic [31:0]         avm_byte_enable,
  output logic [4:0]          avm_burst_count,
  input  logic                avm_waitrequest,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  BL_CNT    = CNT_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] BL_ADDR   = ADDR_W'(BURST_LEN);
  localparam logic [4:0]        BL_AVM    = 5'(BURST_LEN);
  localparam logic [3:0]        LAST_BEAT = 4'(BURST_LEN - 1);

  wr_state_e         state_r;
  wr_state_e         state_nx_s;
  logic [ADDR_W-1:0] addr_r;
  logic [15:0]       num_bursts_r;
  logic [15:0]       burst_cnt_r;
  logic [3:0]        beat_r;
  logic [3:0]        lane_r;
  logic [DATA_W-1:0] pack_r;
  logic [DATA_W-1:0] word_r;
  logic              push_r;
  logic              overflow_r;
  logic              busy_r;
  logic              done_r;
  logic              avm_write_r;
  logic [4:0]        avm_burst_count_r;
  logic [BE_W-1:0]   avm_byte_enable_r;

  logic              start_ok_s;
  logic              capture_s;
  logic              accept_s;
  logic              last_beat_s;
  logic              more_bursts_s;
  logic              fifo_clr_s;
  logic [DATA_W-1:0] fifo_rd_data_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s;

  assign start_ok_s    = start && (state_r == IDLE);
  assign capture_s     = sample_valid && ((state_r == FILL) || (state_r == BURST));
  assign accept_s      = avm_write_r && !avm_waitrequest && !fifo_empty_s;
  assign last_beat_s   = accept_s && (beat_r == LAST_BEAT);
  assign more_bursts_s = ((burst_cnt_r + 16'd1) != num_bursts_r);
  assign fifo_clr_s    = (state_r == DONE);

  adc_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk_200m (clk_200m),
    .reset_n  (reset_n),
    .clr      (fifo_clr_s),
    .wr_en    (push_r),
    .wr_data  (word_r),
    .rd_en    (accept_s),
    .rd_data  (fifo_rd_data_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .count    (fifo_count_s)
  );

  // Next-state logic of the capture FSM.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (num_bursts == 16'd0) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = FILL;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      FILL: begin
        if (fifo_count_s >= BL_CNT) begin
          state_nx_s = BURST;
        end else begin
          state_nx_s = FILL;
        end
      end
      BURST: begin
        if (last_beat_s) begin
          if (more_bursts_s) begin
            state_nx_s = FILL;
          end else begin
            state_nx_s = DONE;
          end
        end else begin
          state_nx_s = BURST;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_200m or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Registered status and Avalon command outputs, aligned with the state they describe.
  always_ff @(posedge clk_200m or negedge reset_n) begin
    if (!reset_n) begin
      avm_write_r       <= 1'b0;
      avm_burst_count_r <= 5'd0;
      avm_byte_enable_r <= {BE_W{1'b0}};
      busy_r            <= 1'b0;
      done_r            <= 1'b0;
    end else begin
      avm_write_r       <= (state_nx_s == BURST);
      avm_burst_count_r <= (state_nx_s == BURST) ? BL_AVM : 5'd0;
      avm_byte_enable_r <= (state_nx_s == BURST) ? {BE_W{1'b1}} : {BE_W{1'b0}};
      busy_r            <= (state_nx_s == FILL) || (state_nx_s == BURST);
      done_r            <= (state_r == DONE);
    end
  end

  // Burst address, burst/beat counters and the sticky overflow flag.
  always_ff @(posedge clk_200m or negedge reset_n) begin
    if (!reset_n) begin
      addr_r       <= {ADDR_W{1'b0}};
      num_bursts_r <= 16'd0;
      burst_cnt_r  <= 16'd0;
      beat_r       <= 4'd0;
      overflow_r   <= 1'b0;
    end else if (start_ok_s) begin
      addr_r       <= base_addr;
      num_bursts_r <= num_bursts;
      burst_cnt_r  <= 16'd0;
      beat_r       <= 4'd0;
      overflow_r   <= 1'b0;
    end else begin
      if (last_beat_s) begin
        addr_r      <= addr_r + BL_ADDR;
        burst_cnt_r <= burst_cnt_r + 16'd1;
        beat_r      <= 4'd0;
      end else if (accept_s) begin
        beat_r <= beat_r + 4'd1;
      end
      if (push_r && fifo_full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Sample packer: fills lanes 0..15, hands the completed word to a holding
  // register so the next sample can start a new word in the push cycle.
  always_ff @(posedge clk_200m or negedge reset_n) begin
    if (!reset_n) begin
      lane_r <= 4'd0;
      pack_r <= {DATA_W{1'b0}};
      word_r <= {DATA_W{1'b0}};
      push_r <= 1'b0;
    end else if (start_ok_s || (state_r == DONE)) begin
      lane_r <= 4'd0;
      push_r <= 1'b0;
    end else begin
      push_r <= capture_s && (lane_r == 4'd15);
      if (capture_s) begin
        pack_r <= put_lane(pack_r, lane_r, sample_data);
        lane_r <= lane_r + 4'd1;
        if (lane_r == 4'd15) begin
          word_r <= put_lane(pack_r, lane_r, sample_data);
        end
      end
    end
  end

  assign avm_write       = avm_write_r;
  assign avm_addr        = avm_write_r ? addr_r : {ADDR_W{1'b0}};
  assign avm_write_data  = avm_write_r ? fifo_rd_data_s : {DATA_W{1'b0}};
  assign avm_byte_enable = avm_byte_enable_r;
  assign avm_burst_count = avm_burst_count_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign overflow        = overflow_r;

endmodule

// File: tb/tb_adc_ddr3_writer.sv
// Directed scoreboard bench for adc_ddr3_writer: expected beats and burst
// addresses are queued as samples are driven and checked as beats are accepted.
module tb_adc_ddr3_writer;
  import adc_ddr3_pkg::*;

  localparam int BURST_LEN = 8;

  logic         clk_200m;
  logic         reset_n;
  logic         start;
  logic [21:0]  base_addr;
  logic [15:0]  num_bursts;
  logic         sample_valid;
  logic [13:0]  sample_data;
  logic         avm_write;
  logic [21:0]  avm_addr;
  logic [255:0] avm_write_data;
  logic [31:0]  avm_byte_enable;
  logic [4:0]   avm_burst_count;
  logic         avm_waitrequest;
  logic         busy;
  logic         done;
  logic         overflow;

  adc_ddr3_writer #(.BURST_LEN(BURST_LEN), .FIFO_DEPTH(32)) dut (
    .clk_200m        (clk_200m),
    .reset_n         (reset_n),
    .start           (start),
    .base_addr       (base_addr),
    .num_bursts      (num_bursts),
    .sample_valid    (sample_valid),
    .sample_data     (sample_data),
    .avm_write       (avm_write),
    .avm_addr        (avm_addr),
    .avm_write_data  (avm_write_data),
    .avm_byte_enable (avm_byte_enable),
    .avm_burst_count (avm_burst_count),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .overflow        (overflow)
  );

  initial begin
    clk_200m = 1'b0;
    forever #5 clk_200m = ~clk_200m;
  end

  int total = 0;
  int bad   = 0;

  logic [255:0] exp_data_q[$];
  logic [21:0]  exp_addr_q[$];
  logic [255:0] first_beats[$];
  logic [21:0]  cur_addr = 22'd0;
  logic [21:0]  last_burst_addr = 22'd0;
  int           beat_in_burst = 0;
  int           beats_acc = 0;
  int           done_cnt = 0;
  int           write_cycles = 0;

  int           sb_lane = 0;
  int           sb_words_left = 0;
  logic [255:0] sb_word = 256'd0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: sees signals half a cycle before the edge that acts on them.
  initial begin
    forever begin
      @(negedge clk_200m);
      if (!reset_n) begin
        exp_data_q.delete();
        exp_addr_q.delete();
        beat_in_burst = 0;
      end else begin
        if (done) done_cnt++;
        if (avm_write) write_cycles++;
        if (avm_write && !avm_waitrequest) begin
          if (beat_in_burst == 0) begin
            first_beats.push_back(avm_write_data);
            last_burst_addr = avm_addr;
            total++;
            assert (exp_addr_q.size() > 0) else begin
              bad++;
              $error("FAIL extra_burst observed=%0h expected=none", avm_addr);
            end
            if (exp_addr_q.size() > 0) cur_addr = exp_addr_q.pop_front();
            chk("burst_count", 256'(avm_burst_count), 256'(BURST_LEN));
            chk("byte_enable", 256'(avm_byte_enable), 256'(32'hFFFF_FFFF));
          end
          chk("burst_addr", 256'(avm_addr), 256'(cur_addr));
          total++;
          assert (exp_data_q.size() > 0) else begin
            bad++;
            $error("FAIL extra_beat observed=%0h expected=none", avm_write_data);
          end
          if (exp_data_q.size() > 0) chk("beat_data", avm_write_data, exp_data_q.pop_front());
          beat_in_burst = (beat_in_burst == BURST_LEN - 1) ? 0 : beat_in_burst + 1;
          beats_acc++;
        end
      end
    end
  end

  task automatic pulse_start(input logic [21:0] base, input logic [15:0] nb);
    start = 1'b1;
    base_addr = base;
    num_bursts = nb;
    @(posedge clk_200m); #1;
    start = 1'b0;
  endtask

  task automatic do_start(input logic [21:0] base, input logic [15:0] nb);
    sb_lane = 0;
    sb_words_left = int'(nb) * BURST_LEN;
    for (int i = 0; i < int'(nb); i++) exp_addr_q.push_back(22'(int'(base) + i * BURST_LEN));
    pulse_start(base, nb);
  endtask

  task automatic feed(input int n, input int first, input int step);
    for (int i = 0; i < n; i++) begin
      logic [13:0] s;
      s = 14'(first + i * step);
      sample_valid = 1'b1;
      sample_data = s;
      sb_word[sb_lane*16 +: 16] = {2'b00, s};
      if (sb_lane == 15) begin
        if (sb_words_left > 0) begin
          exp_data_q.push_back(sb_word);
          sb_words_left--;
        end
        sb_lane = 0;
      end else begin
        sb_lane++;
      end
      @(posedge clk_200m); #1;
    end
    sample_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) break;
      @(posedge clk_200m); #1;
    end
    repeat (3) begin @(posedge clk_200m); #1; end
    chk({tag, "_done_pulses"}, 256'(done_cnt - d0), 256'(1));
    chk({tag, "_beats_left"}, 256'(exp_data_q.size()), 256'(0));
  endtask

  task automatic wait_beats(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (beats_acc == target) break;
      @(posedge clk_200m); #1;
    end
    chk("beat_wait", 256'(beats_acc), 256'(target));
  endtask

  int           a0;
  int           b0;
  int           wc0;
  logic [255:0] held;
  logic [255:0] fb;

  initial begin
    reset_n = 1'b0; start = 1'b0; base_addr = 22'd0; num_bursts = 16'd0;
    sample_valid = 1'b0; sample_data = 14'd0; avm_waitrequest = 1'b0;
    repeat (3) @(posedge clk_200m); #1;
    chk("rst_write", 256'(avm_write), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_overflow", 256'(overflow), 256'(0));
    chk("rst_addr", 256'(avm_addr), 256'(0));
    chk("rst_data", avm_write_data, 256'(0));
    reset_n = 1'b1;
    @(posedge clk_200m); #1;

    // Basic capture with a start pulse while busy.
    b0 = first_beats.size();
    do_start(22'h000100, 16'd2);
    chk("busy_latency", 256'(busy), 256'(1));
    feed(64, 0, 1);
    pulse_start(22'h002222, 16'd5);
    chk("start_ignored_busy", 256'(busy), 256'(1));
    feed(192, 64, 1);
    wait_done("basic", 400);
    chk("basic_bursts", 256'(first_beats.size() - b0), 256'(2));
    fb = (first_beats.size() > b0) ? first_beats[b0] : 256'd0;
    chk("basic_lane0", 256'(fb[15:0]), 256'(16'h0000));
    chk("basic_lane15", 256'(fb[255:240]), 256'(16'h000F));
    chk("basic_busy_low", 256'(busy), 256'(0));

    // Backpressure: 5-cycle stall on beat 3.
    a0 = beats_acc;
    do_start(22'h001000, 16'd1);
    feed(128, 256, 3);
    wait_beats(a0 + 3, 60);
    avm_waitrequest = 1'b1;
    held = avm_write_data;
    repeat (5) begin
      @(posedge clk_200m); #1;
      chk("stall_data", avm_write_data, held);
      chk("stall_write", 256'(avm_write), 256'(1));
    end
    chk("stall_no_accept", 256'(beats_acc - a0), 256'(3));
    avm_waitrequest = 1'b0;
    wait_done("bp", 100);
    chk("bp_beats", 256'(beats_acc - a0), 256'(8));

    // Overflow: slave stalled while 600 samples arrive.
    a0 = beats_acc;
    avm_waitrequest = 1'b1;
    do_start(22'h002000, 16'd1);
    feed(512, 0, 1);
    repeat (3) begin @(posedge clk_200m); #1; end
    chk("ovf_32_words", 256'(overflow), 256'(0));
    feed(16, 512, 1);
    repeat (3) begin @(posedge clk_200m); #1; end
    chk("ovf_33_words", 256'(overflow), 256'(1));
    feed(72, 528, 1);
    chk("ovf_sticky", 256'(overflow), 256'(1));
    avm_waitrequest = 1'b0;
    wait_done("ovf", 100);
    chk("ovf_beats", 256'(beats_acc - a0), 256'(8));

    // num_bursts = 0: done two cycles after start, no write, overflow cleared.
    wc0 = write_cycles;
    do_start(22'h003000, 16'd0);
    chk("zero_ovf_clear", 256'(overflow), 256'(0));
    chk("zero_done_early", 256'(done), 256'(0));
    chk("zero_busy", 256'(busy), 256'(0));
    @(posedge clk_200m); #1;
    chk("zero_done", 256'(done), 256'(1));
    @(posedge clk_200m); #1;
    chk("zero_done_end", 256'(done), 256'(0));
    chk("zero_no_write", 256'(write_cycles - wc0), 256'(0));

    // Address wrap at the top of the 22-bit space.
    do_start(22'h3FFFF8, 16'd2);
    feed(256, 4096, 7);
    wait_done("wrap", 400);
    chk("wrap_addr", 256'(last_burst_addr), 256'(22'h000000));

    // Reset on beat 4 of a burst, then a clean capture.
    a0 = beats_acc;
    do_start(22'h000200, 16'd1);
    feed(128, 5, 11);
    wait_beats(a0 + 4, 60);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_write", 256'(avm_write), 256'(0));
    chk("mid_rst_busy", 256'(busy), 256'(0));
    chk("mid_rst_done", 256'(done), 256'(0));
    chk("mid_rst_overflow", 256'(overflow), 256'(0));
    chk("mid_rst_addr", 256'(avm_addr), 256'(0));
    chk("mid_rst_bcount", 256'(avm_burst_count), 256'(0));
    chk("mid_rst_be", 256'(avm_byte_enable), 256'(0));
    chk("mid_rst_data", avm_write_data, 256'(0));
    chk("mid_rst_state", 256'(dut.state_r), 256'(IDLE));
    repeat (2) @(posedge clk_200m); #1;
    reset_n = 1'b1;
    wc0 = write_cycles;
    repeat (6) begin @(posedge clk_200m); #1; end
    chk("post_rst_no_write", 256'(write_cycles - wc0), 256'(0));
    a0 = beats_acc;
    do_start(22'h000300, 16'd1);
    feed(128, 0, 1);
    wait_done("post_rst", 100);
    chk("post_rst_beats", 256'(beats_acc - a0), 256'(8));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_ddr3_writer.md
ADC_DDR3_WRITER -- requirements
Module: adc_ddr3_writer

Interface
REQ-001 SHALL have parameter BURST_LEN, default 8: 256-bit beats per DDR3 write burst; legal values 1..16.
REQ-002 SHALL have parameter FIFO_DEPTH, default 32: 256-bit words in the internal buffer; power of two, at least 2*BURST_LEN.
REQ-003 SHALL have port clk_200m, input, 1: sole clock; the Avalon-MM master side is synchronous to it.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: single-cycle pulse that begins a capture.
REQ-006 SHALL have port base_addr, input, 22: first DDR3 word address, sampled on start.
REQ-007 SHALL have port num_bursts, input, 16: number of bursts to write, sampled on start.
REQ-008 SHALL have port sample_valid, input, 1: qualifies sample_data.
REQ-009 SHALL have port sample_data, input, 14: ADC sample.
REQ-010 SHALL have port avm_write, output, 1: Avalon-MM write request.
REQ-011 SHALL have port avm_addr, output, 22: burst start word address.
REQ-012 SHALL have ports avm_write_data (output, 256) and avm_byte_enable (output, 32): write beat and byte enables.
REQ-013 SHALL have port avm_burst_count, output, 5: burst length.
REQ-014 SHALL have port avm_waitrequest, input, 1: slave stall.
REQ-015 SHALL have ports busy, done and overflow, outputs, 1 each: capture active, one-cycle completion pulse, sticky drop flag.

Function
REQ-016 SHALL leave IDLE only on start; a start pulse while busy is ignored.
REQ-017 SHALL, on accepting start, latch base_addr and num_bursts, clear overflow and the packing lane index, and go to FILL.
REQ-018 SHALL pack samples only while busy: on each sample_valid, lane k (0..15) receives {2'b00, sample_data} at bits [16k+15:16k], and lane 0 is the first sample.
REQ-019 SHALL push the packed word into the FIFO in the cycle after lane 15 is written; the 16th valid sample completes a word, and the packer continues without a gap.
REQ-020 SHALL drop the word and set overflow until the next start when a push finds the FIFO full; packing of later samples continues.
REQ-021 SHALL move the FSM from FILL to BURST when the FIFO holds at least BURST_LEN words.
REQ-022 SHALL, in BURST, hold avm_write high with avm_burst_count = BURST_LEN, avm_byte_enable all ones and avm_addr equal to the current burst address, constant for the whole burst.
REQ-023 SHALL drive avm_write_data from the FIFO head; a beat is accepted when avm_write is high and avm_waitrequest is low, and only an accepted beat pops the FIFO.
REQ-024 SHALL hold avm_write_data stable while avm_waitrequest is high.
REQ-025 SHALL, after the last accepted beat of a burst, add BURST_LEN to the burst address (modulo 2^22, wrap allowed) and increment the burst counter.
REQ-026 SHALL go from BURST to FILL when bursts remain, otherwise to DONE.
REQ-027 SHALL, in DONE, pulse done for exactly one cycle, drop busy, and return to IDLE in the next cycle; leftover FIFO words and partial packs are discarded.
REQ-028 SHALL, when num_bursts = 0, go from start directly to DONE with no avm_write.
REQ-029 SHALL give a latency of 1 cycle from the cycle start is sampled to busy = 1.
REQ-030 SHALL make a simultaneous FIFO push and pop in the same cycle legal, leaving the occupancy unchanged.

Reset
REQ-031 SHALL, with reset_n low, force the FSM to IDLE and clear the FIFO pointers, lane index, burst counter and address.
REQ-032 SHALL, with reset_n low, drive avm_write, busy, done and overflow to 0, and avm_addr, avm_burst_count, avm_byte_enable and avm_write_data to 0.
REQ-033 SHALL, on reset mid-burst, abandon the burst immediately with no further beats after release.

Structure
REQ-034 SHALL place LANES=16, LANE_W=16, DATA_W=256, ADDR_W=22, BE_W=32 and the FSM state enumeration (IDLE, FILL, BURST, DONE) in shared package adc_ddr3_pkg.
REQ-035 SHALL implement the buffer as one sub-module, adc_word_fifo: synchronous, show-ahead, with full/empty/count outputs.

Verification
REQ-036 Bench SHALL check a basic capture: base_addr=0x000100, num_bursts=2, BURST_LEN=8, 256 ramp samples 0..255 with no waitrequest -> 2 bursts at 0x000100 and 0x000108; beat 0 lane 0 = 0x0000, lane 15 = 0x000F; one done pulse.
REQ-037 Bench SHALL check backpressure: waitrequest high for 5 cycles on beat 3 -> data stable during the stall, no beat lost or duplicated, 8 beats accepted.
REQ-038 Bench SHALL check overflow: waitrequest held high with 600 continuous samples -> overflow=1 after the 33rd completed word, then cleared by the next start.
REQ-039 Bench SHALL check address wrap: base_addr=0x3FFFF8, num_bursts=2 -> second burst at 0x000000.
REQ-040 Bench SHALL check boundary cases: num_bursts=0 -> done 2 cycles after start with no write; start while busy -> ignored.
REQ-041 Bench SHALL check reset mid-burst: reset_n low on beat 4 -> all outputs 0, FSM IDLE, and a subsequent capture is correct.
